// File: rtl/mjpg_bs_scheduler.sv
// rtl/mjpg_bs_scheduler.sv - MJPG bitstream packer slot scheduler (optional checker: MJPG_SCHED_COLLISION_CHK_EN)
module mjpg_bs_scheduler #(
    parameter int HDR_LEN   = 171,
    parameter int HDR_FIRST = 2,
    parameter int Y_CYC     = 29,
    parameter int C_CYC     = 7,
    parameter int GUARD_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sof,
    input  logic        row_ready,
    input  logic [7:0]  h_mcu,
    input  logic [17:0] ce_len,
    output logic        align_req,
    output logic        hdr_req,
    output logic [7:0]  hdr_idx,
    output logic [2:0]  ce_req,
    output logic [7:0]  e_x_mcu,
    output logic        row_done,
    output logic        busy,
    output logic        overrun,
    output logic        collide
);

    // One shared window counter, wide enough for the longest window plus one.
    localparam int CNT_MAX = (Y_CYC > C_CYC) ? ((Y_CYC > GUARD_CYC) ? Y_CYC : GUARD_CYC)
                                             : ((C_CYC > GUARD_CYC) ? C_CYC : GUARD_CYC);
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_HDR, S_WAIT_ROW, S_Y, S_CB, S_CR, S_GUARD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      hmcu_q, hmcu_d;
    logic [7:0]      idx_d;
    logic [7:0]      x_d;
    logic            row_done_d;
    logic            overrun_d;
    logic            in_row;

    assign in_row = (state_q == S_Y) || (state_q == S_CB) || (state_q == S_CR) || (state_q == S_GUARD);

    // Next-state and next-output decode; sof overrides everything as a frame abort/restart.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hmcu_d     = hmcu_q;
        idx_d      = hdr_idx;
        x_d        = e_x_mcu;
        row_done_d = 1'b0;
        overrun_d  = overrun;
        case (state_q)
            S_IDLE: ;
            S_ALIGN: begin
                state_d = S_HDR;
                idx_d   = 8'(HDR_FIRST);
            end
            S_HDR: begin
                if (hdr_idx == 8'(HDR_LEN - 1)) begin
                    state_d = S_WAIT_ROW;
                    idx_d   = 8'd0;
                end else begin
                    idx_d = hdr_idx + 8'd1;
                end
            end
            S_WAIT_ROW: begin
                if (row_ready) begin
                    hmcu_d = h_mcu;
                    if (h_mcu != 8'd0) begin
                        state_d = S_Y;
                        cnt_d   = '0;
                        x_d     = 8'd0;
                    end else begin
                        row_done_d = 1'b1;
                    end
                end
            end
            S_Y: begin
                if (cnt_q == CW'(Y_CYC - 1)) begin
                    state_d = S_CB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CB: begin
                if (cnt_q == CW'(C_CYC - 1)) begin
                    state_d = S_CR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CR: begin
                if (cnt_q == CW'(C_CYC - 1)) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GUARD: begin
                if (cnt_q == CW'(GUARD_CYC - 1)) begin
                    cnt_d = '0;
                    if (({1'b0, e_x_mcu} + 9'd1) < {1'b0, hmcu_q}) begin
                        state_d = S_Y;
                        x_d     = e_x_mcu + 8'd1;
                    end else begin
                        state_d    = S_WAIT_ROW;
                        x_d        = 8'd0;
                        row_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (row_ready && in_row) begin
            overrun_d = 1'b1;
        end
        if (sof) begin
            state_d    = S_ALIGN;
            cnt_d      = '0;
            idx_d      = 8'd0;
            x_d        = 8'd0;
            row_done_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hmcu_q    <= 8'd0;
            align_req <= 1'b0;
            hdr_req   <= 1'b0;
            hdr_idx   <= 8'd0;
            ce_req    <= 3'b000;
            e_x_mcu   <= 8'd0;
            row_done  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hmcu_q    <= hmcu_d;
            align_req <= (state_d == S_ALIGN);
            hdr_req   <= (state_d == S_HDR);
            hdr_idx   <= idx_d;
            ce_req    <= {state_d == S_CR, state_d == S_CB, state_d == S_Y};
            e_x_mcu   <= x_d;
            row_done  <= row_done_d;
            busy      <= (state_d != S_IDLE) && (state_d != S_WAIT_ROW);
            overrun   <= overrun_d;
        end
    end

`ifdef MJPG_SCHED_COLLISION_CHK_EN
    logic       fh_prev_q;
    logic [2:0] nz;
    logic       multi_nz;

    assign nz       = {|ce_len[17:12], |ce_len[11:6], |ce_len[5:0]};
    assign multi_nz = (nz[0] & nz[1]) | (nz[0] & nz[2]) | (nz[1] & nz[2]);

    // Sticky flag: two encoders writing at once, or an encoder writing right after a header slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fh_prev_q <= 1'b0;
            collide   <= 1'b0;
        end else begin
            fh_prev_q <= align_req | hdr_req;
            if (multi_nz || ((|nz) && fh_prev_q)) begin
                collide <= 1'b1;
            end
        end
    end
`else
    logic unused_ce_len;
    assign unused_ce_len = ^ce_len;
    assign collide       = 1'b0;
`endif

endmodule
